// File: rtl/rx_uart.sv
`timescale 1ns/1ps
// rtl/rx_uart.sv - UART receiver: 2-flop input synchroniser, 16x oversampling FSM, FWFT byte FIFO
// with sticky overrun/framing flags and a baud-divisor config register.
module rx_uart #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [7:0]  DEFAULT_DIVISOR = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic [7:0] config_data,
  input  logic       config_enable,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       data_valid,
  output logic       overrun,
  output logic       framing_error
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic          sync1_q, sync2_q, rxs_prev_q;
  logic [7:0]    divisor_q, prescaler_q, shift_q;
  logic [3:0]    tick_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, framing_error_q;

  logic rxs, tick, stop_sample, fifo_empty, fifo_full;
  logic push_req, push, pop, drop, frame_err;

  assign rxs         = sync2_q;
  assign tick        = (prescaler_q == divisor_q);
  assign stop_sample = (state_q == STOP) && tick && (tick_cnt_q == 4'd15);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign pop         = read_enable && !fifo_empty;
  assign push_req    = stop_sample && rxs && !config_enable;
  assign push        = push_req && (!fifo_full || pop);
  assign drop        = push_req && fifo_full && !pop;
  assign frame_err   = stop_sample && !rxs;

  assign read_data     = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_valid    = !fifo_empty;
  assign overrun       = overrun_q;
  assign framing_error = framing_error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_line;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      divisor_q   <= DEFAULT_DIVISOR;
      prescaler_q <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
    end else if (config_enable) begin
      divisor_q   <= config_data;
      state_q     <= IDLE;
      prescaler_q <= '0;
    end else begin
      prescaler_q <= tick ? 8'd0 : prescaler_q + 8'd1;
      case (state_q)
        IDLE: begin
          // Restart the bit clock so the 8th tick lands mid start bit.
          if (rxs_prev_q && !rxs) begin
            state_q     <= START;
            prescaler_q <= '0;
            tick_cnt_q  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == 4'd7) begin
              if (!rxs) begin
                state_q    <= DATA;
                tick_cnt_q <= '0;
                bit_idx_q  <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd15) begin
              shift_q   <= {rxs, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd15) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overrun_q       <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (config_enable) begin
        overrun_q       <= 1'b0;
        framing_error_q <= 1'b0;
      end else begin
        if (drop)      overrun_q       <= 1'b1;
        if (frame_err) framing_error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

endmodule

// File: tb/tb_rx_uart.sv
`timescale 1ns/1ps
// tb/tb_rx_uart.sv - randomized self-checking bench for rx_uart against a queue-based receive model
module tb_rx_uart;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] config_data = 8'h00;
  logic       config_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic [7:0] read_data;
  logic       data_valid, overrun, framing_error;

  rx_uart #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(8'd3)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line),
    .config_data(config_data), .config_enable(config_enable),
    .read_enable(read_enable), .read_data(read_data),
    .data_valid(data_valid), .overrun(overrun), .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  // A frame whose line falls just before posedge e1 completes its mid-stop sample
  // 2 sync cycles + 1 detect cycle + 152 ticks later; the byte is visible after that edge.
  typedef struct { int t; logic [7:0] b; bit err; } ev_t;
  ev_t        pend[$];
  logic [7:0] mq[$];
  bit         m_ovr = 1'b0, m_fe = 1'b0;
  int         mdiv = 3;
  int         cyc = 0;
  bit         chk = 1'b0;
  bit         rdone;
  int         rprob;
  int         n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    ev_t it;
    bit  arr, do_pop;
    cyc++;
    if (rst) begin
      mq.delete(); pend.delete();
      m_ovr = 1'b0; m_fe = 1'b0; mdiv = 3;
    end else begin
      do_pop = read_enable && (mq.size() > 0);
      arr = 1'b0;
      if (pend.size() > 0 && pend[0].t == cyc) begin
        arr = 1'b1;
        it = pend.pop_front();
      end
      if (config_enable) begin
        mdiv = int'(config_data);
        m_ovr = 1'b0; m_fe = 1'b0;
        pend.delete();
        arr = 1'b0;
      end
      if (do_pop) void'(mq.pop_front());
      if (arr) begin
        if (it.err)                m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(it.b);
        else                        m_ovr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] er;
    if (chk) begin
      er = (mq.size() > 0) ? mq[0] : 8'h00;
      check($sformatf("cycle_model@%0d", cyc),
            {21'd0, read_data, data_valid, overrun, framing_error},
            {21'd0, er, mq.size() > 0, m_ovr, m_fe});
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_at);
    logic [9:0] bits;
    int bp;
    bits = {stop_ok, b, 1'b0};
    bp = 16 * (mdiv + 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst = 1'b1; rx_line = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rx_line = bits[i];
      if (i == 0) pend.push_back('{cyc + 3 + 152 * (mdiv + 1), b, !stop_ok});
      repeat (bp - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg(input logic [7:0] v);
    @(negedge clk);
    config_data = v; config_enable = 1'b1;
    @(negedge clk);
    config_enable = 1'b0;
  endtask

  task automatic rd(input logic [7:0] exp, input string nm);
    check(nm, {23'd0, data_valid, read_data}, {23'd0, 1'b1, exp});
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk = 1'b1;
    check("reset_state", {20'd0, read_data, data_valid, overrun, framing_error, 1'b0}, 32'd0);

    // Default divisor 3, then reset in the middle of a frame.
    send_frame(8'hFF, 1'b1, -1);
    check("t6_ff", {23'd0, data_valid, read_data}, {23'd0, 1'b1, 8'hFF});
    send_frame(8'h00, 1'b1, 5);
    check("t6_rst_outputs", {21'd0, read_data, data_valid, overrun, framing_error}, 32'd0);
    repeat (700) @(negedge clk);
    check("t6_no_push", {31'd0, data_valid}, 32'd0);
    send_frame(8'h81, 1'b1, -1);
    rd(8'h81, "t6_0x81");

    // Divisor 0: latency bound on 0xA5, then pop.
    cfg(8'h00);
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        n = 0;
        while (!data_valid && n < 200) begin @(negedge clk); n++; end
        check("t1_latency_ok", {31'd0, n <= 165}, 32'd1);
      end
    join
    rd(8'hA5, "t1_0xA5");
    check("t1_after_pop", {23'd0, data_valid, read_data}, 32'd0);

    // Short glitch is a false start.
    @(negedge clk); rx_line = 1'b0;
    repeat (2) @(negedge clk); rx_line = 1'b1;
    repeat (40) @(negedge clk);
    check("t2_glitch", {30'd0, data_valid, framing_error}, 32'd0);
    send_frame(8'h3C, 1'b1, -1);
    rd(8'h3C, "t2_0x3C");

    // Framing error and clear by config write.
    send_frame(8'h55, 1'b0, -1);
    check("t3_fe_set", {30'd0, framing_error, data_valid}, 32'd2);
    cfg(8'h00);
    check("t3_fe_clr", {31'd0, framing_error}, 32'd0);

    // Overflow.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, -1);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 8; i++) rd(8'(i + 1), $sformatf("t4_read%0d", i));
    check("t4_empty", {31'd0, data_valid}, 32'd0);

    // Pop coincident with push into a full FIFO.
    cfg(8'h00);
    check("t5_ovr_clr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + i), 1'b1, -1);
    fork
      send_frame(8'h19, 1'b1, -1);
      begin
        n = 0;
        while (pend.size() == 0 && n < 400) begin @(negedge clk); n++; end
        while (pend.size() > 0 && cyc != pend[0].t - 1 && n < 400) begin @(negedge clk); n++; end
        check("t5_sync", {31'd0, n < 400}, 32'd1);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
      end
    join
    check("t5_no_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 8; i++) rd(8'(8'h12 + i), $sformatf("t5_read%0d", i));
    check("t5_empty", {31'd0, data_valid}, 32'd0);

    // Random traffic: bytes, divisors, bad stop bits, sparse then dense reads.
    rdone = 1'b0;
    rprob = 400;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          if (f == 20) rprob = 10;
          if ($urandom_range(0, 5) == 0) cfg(8'($urandom_range(0, 2)));
          send_frame(8'($urandom), $urandom_range(0, 7) != 0, -1);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(negedge clk);
          read_enable = ($urandom_range(0, rprob - 1) == 0);
        end
        read_enable = 1'b0;
      end
    join
    n = 0;
    while (data_valid && n < 20) begin
      read_enable = 1'b1; @(negedge clk); n++;
    end
    read_enable = 1'b0;
    @(negedge clk);
    check("drain_empty", {31'd0, data_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
